trigger_frame_reader: RTL
=========================

Name: trigger_frame_reader

Overview:
- Reader side of the oscilloscope capture path; the trigger detector and sample writer fill a circular sample memory and report the trigger address.
- After arming, this block waits for a trigger event and computes the frame start address (trigger address minus pre-trigger count, modulo memory depth).
- It then reads frame_len samples from the memory through a 1-cycle-latency read port and streams them out on a valid/ready interface, marking the last sample.

Parameters:
- DATA_WIDTH, 16, sample width.
- ADDR_W, 12, sample memory address width; depth = 2^ADDR_W.
- LEN_W, 16, width of frame_len and pre_trig.
- TIMEOUT_W, 24, width of auto-trigger timeout (used only with the optional feature).

Ports:
- clk  in  1  sole clock.
- rst  in  1  reset; asynchronous, active-low.
- arm  in  1  one-cycle pulse; starts a capture cycle (ignored unless IDLE or DONE).
- frame_len  in  LEN_W  samples per frame; sampled on arm; 0 is treated as 1.
- pre_trig  in  LEN_W  samples before trigger; sampled on arm; clamped to frame_len-1.
- trig_valid  in  1  one-cycle pulse from the trigger detector.
- trig_addr  in  ADDR_W  sample address of the trigger; valid with trig_valid.
- rd_en  out  1  memory read strobe.
- rd_addr  out  ADDR_W  memory read address.
- rd_data  in  DATA_WIDTH  read data, valid exactly 1 cycle after rd_en.
- m_data  out  DATA_WIDTH  output sample.
- m_valid  out  1  output valid.
- m_last  out  1  high with the final sample of the frame.
- m_ready  in  1  downstream ready.
- busy  out  1  high in WAIT_TRIG and READ.
- done  out  1  one-cycle pulse when the last sample handshakes.
- frame_start  out  ADDR_W  computed start address of the current frame.

Behaviour:
- Reset values: all outputs 0; FSM state IDLE; output buffer empty; any in-flight read is discarded.
- FSM states and transitions:
  - IDLE: on arm, go to WAIT_TRIG.
  - WAIT_TRIG: on trig_valid, go to READ and compute frame_start = (trig_addr - pre_trig_clamped) mod 2^ADDR_W.
  - READ: when the last sample handshakes (m_valid & m_ready & m_last), go to DONE.
  - DONE: on arm, go to WAIT_TRIG; otherwise hold.
  - trig_valid is ignored outside WAIT_TRIG.
  - arm in WAIT_TRIG or READ is ignored.
  - If arm and trig_valid arrive in the same cycle while in IDLE, only arm takes effect.
- Read issue:
  - rd_addr starts at frame_start and increments by 1, wrapping naturally at 2^ADDR_W.
  - Exactly frame_len reads are issued.
  - The first rd_en occurs in the cycle after entering READ.
- Flow control:
  - 2-entry output buffer.
  - Issue a read only when (buffer occupancy + reads in flight) < 2; at most one read is issued per cycle.
  - No sample is ever dropped or duplicated under any m_ready pattern.
- Throughput and latency:
  - With m_ready held high, throughput is 1 sample/cycle.
  - First m_valid appears 2 cycles after trig_valid.
- Output hold rule: m_data, m_last and m_valid hold stable while m_valid & !m_ready.
- m_last is asserted on sample index frame_len-1 only.
- done pulses in the same cycle as the handshake of the last sample.
- Counters are LEN_W wide; frame_len > 2^ADDR_W is allowed and simply re-reads wrapped addresses.

Optional Feature:
- Macro: TRIG_AUTO_EN.
- Enabled:
  - Adds input auto_timeout [TIMEOUT_W], sampled on arm.
  - In WAIT_TRIG, a counter increments every cycle. When it reaches auto_timeout (nonzero) with no trig_valid, the block behaves as if triggered at the current write-side address, taken from an added input wr_addr [ADDR_W].
  - Adds output auto_fired, high from that forced trigger until the next arm.
  - auto_timeout = 0 disables the timeout.
  - A real trig_valid in the same cycle as the timeout takes precedence and leaves auto_fired = 0.
- Disabled: none of these ports exist; WAIT_TRIG waits indefinitely.

Decomposition:
- Shared package (osc_pkg):
  - FSM state encoding (IDLE, WAIT_TRIG, READ, DONE).
  - Default DATA_WIDTH and ADDR_W constants, shared with the trigger detector and sample writer.
- Sub-module osc_out_fifo2: the 2-entry valid/ready buffer with occupancy output. The FSM and read issue logic stay in the top module.

Test Plan:
- Basic frame:
  - Stimulus: frame_len=8, pre_trig=3, arm, then trig_valid with trig_addr=100, m_ready=1.
  - Required: rd_addr 97..104, 8 samples match memory contents, m_last on the 8th, done pulse, state DONE.
- Wrap-around:
  - Stimulus: ADDR_W=12, trig_addr=2, pre_trig=5, frame_len=10.
  - Required: rd_addr 4093,4094,4095,0..6; frame_start=4093.
- Backpressure:
  - Stimulus: frame_len=16; m_ready toggles 1,0,0,1 repeatedly plus random patterns.
  - Required: all 16 samples delivered in order, none lost or duplicated, m_data stable while stalled, rd_en never issued with 2 entries committed.
- Ignored events:
  - Stimulus: trig_valid while IDLE; arm during READ; second trig_valid during READ.
  - Required: no state change; frame unaffected.
- Reset mid-frame:
  - Stimulus: assert rst low after 5 of 8 samples.
  - Required: m_valid=0, busy=0, state IDLE immediately (asynchronous). A new arm then trig_valid yields a clean full frame.
- Clamping and auto-trigger:
  - Stimulus: frame_len=0 gives one sample with m_last=1; pre_trig=20 with frame_len=8 is clamped to 7.
  - Stimulus (TRIG_AUTO_EN only): auto_timeout=50, no trigger, wr_addr=300.
  - Required: auto-trigger fires after 50 cycles, frame_start=300-pre_trig, auto_fired=1.

Source files
------------

// File: rtl/osc_pkg.sv
// Shared definitions for the oscilloscope capture path: reader FSM states and
// default sample/address widths used by the trigger detector and sample writer.
package osc_pkg;

    localparam int OSC_DATA_WIDTH = 16;
    localparam int OSC_ADDR_W     = 12;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_TRIG = 2'd1,
        ST_READ      = 2'd2,
        ST_DONE      = 2'd3
    } osc_state_e;

    // Samples already owed to the output buffer: stored entries plus the read in flight.
    function automatic logic [1:0] osc_committed(input logic [1:0] occ, input logic inflight);
        return occ + {1'b0, inflight};
    endfunction

endpackage

// File: rtl/osc_out_fifo2.sv
// Two-entry valid/ready output buffer with a combinational bypass when empty,
// so a sample arriving from memory can leave in the same cycle.
module osc_out_fifo2 #(
    parameter int W = 17
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    input  logic         out_ready,
    output logic [1:0]   count
);

    logic [W-1:0] mem0_r, mem1_r, mem0_nx_s, mem1_nx_s;
    logic [1:0]   count_r, count_nx_s;
    logic         pop_s;

    assign out_valid = (count_r != 2'd0) || in_valid;
    assign out_data  = (count_r != 2'd0) ? mem0_r : (in_valid ? in_data : {W{1'b0}});
    assign pop_s     = out_valid && out_ready;
    assign count     = count_r;

    // Next buffer contents; the producer never pushes into a full buffer.
    always_comb begin
        mem0_nx_s  = mem0_r;
        mem1_nx_s  = mem1_r;
        count_nx_s = count_r;
        case (count_r)
            2'd0: begin
                if (in_valid && !out_ready) begin
                    mem0_nx_s  = in_data;
                    count_nx_s = 2'd1;
                end else begin
                    count_nx_s = 2'd0;
                end
            end
            2'd1: begin
                if (in_valid && pop_s) begin
                    mem0_nx_s = in_data;
                end else if (in_valid) begin
                    mem1_nx_s  = in_data;
                    count_nx_s = 2'd2;
                end else if (pop_s) begin
                    count_nx_s = 2'd0;
                end else begin
                    count_nx_s = 2'd1;
                end
            end
            2'd2: begin
                if (pop_s && in_valid) begin
                    mem0_nx_s = mem1_r;
                    mem1_nx_s = in_data;
                end else if (pop_s) begin
                    mem0_nx_s  = mem1_r;
                    count_nx_s = 2'd1;
                end else begin
                    count_nx_s = 2'd2;
                end
            end
            default: begin
                count_nx_s = 2'd0;
            end
        endcase
    end

    // Buffer storage and occupancy registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem0_r  <= {W{1'b0}};
            mem1_r  <= {W{1'b0}};
            count_r <= 2'd0;
        end else begin
            mem0_r  <= mem0_nx_s;
            mem1_r  <= mem1_nx_s;
            count_r <= count_nx_s;
        end
    end

endmodule

// File: rtl/trigger_frame_reader.sv
// Oscilloscope frame reader: waits for a trigger, reads frame_len samples from the
// circular capture memory starting pre_trig before it. Optional auto-trigger: TRIG_AUTO_EN.
module trigger_frame_reader
    import osc_pkg::*;
#(
    parameter int DATA_WIDTH = OSC_DATA_WIDTH,
    parameter int ADDR_W     = OSC_ADDR_W,
    parameter int LEN_W      = 16
`ifdef TRIG_AUTO_EN
    ,
    parameter int TIMEOUT_W  = 24
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  arm,
    input  logic [LEN_W-1:0]      frame_len,
    input  logic [LEN_W-1:0]      pre_trig,
    input  logic                  trig_valid,
    input  logic [ADDR_W-1:0]     trig_addr,
    output logic                  rd_en,
    output logic [ADDR_W-1:0]     rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    output logic                  m_last,
    input  logic                  m_ready,
    output logic                  busy,
    output logic                  done,
`ifdef TRIG_AUTO_EN
    input  logic [TIMEOUT_W-1:0]  auto_timeout,
    input  logic [ADDR_W-1:0]     wr_addr,
    output logic                  auto_fired,
`endif
    output logic [ADDR_W-1:0]     frame_start
);

    osc_state_e          state_r, state_nx_s;
    logic [LEN_W-1:0]    len_r, pre_r, issued_r, len_eff_s, pre_clamp_s;
    logic [ADDR_W-1:0]   frame_start_r, rd_addr_r, trig_base_s;
    logic                inflight_r, inflight_last_r;
    logic                trig_fire_s, arm_ok_s, issue_s, hs_last_s;
    logic [1:0]          occ_s;
    logic                fifo_valid_s;
    logic [DATA_WIDTH:0] fifo_data_s;

    assign len_eff_s   = (frame_len == {LEN_W{1'b0}}) ? LEN_W'(1'b1) : frame_len;
    assign pre_clamp_s = (pre_trig > len_eff_s - LEN_W'(1'b1)) ? len_eff_s - LEN_W'(1'b1) : pre_trig;
    assign arm_ok_s    = arm && ((state_r == ST_IDLE) || (state_r == ST_DONE));

`ifdef TRIG_AUTO_EN
    logic [TIMEOUT_W-1:0] timeout_r, tcnt_r;
    logic                 auto_fired_r, auto_hit_s;

    assign auto_hit_s  = (state_r == ST_WAIT_TRIG) && (timeout_r != {TIMEOUT_W{1'b0}})
                         && (tcnt_r + TIMEOUT_W'(1'b1) == timeout_r);
    assign trig_fire_s = (state_r == ST_WAIT_TRIG) && (trig_valid || auto_hit_s);
    // A real trigger wins over a timeout landing in the same cycle.
    assign trig_base_s = trig_valid ? trig_addr : wr_addr;
    assign auto_fired  = auto_fired_r;

    // Auto-trigger timeout counter and sticky fired flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timeout_r    <= {TIMEOUT_W{1'b0}};
            tcnt_r       <= {TIMEOUT_W{1'b0}};
            auto_fired_r <= 1'b0;
        end else if (arm_ok_s) begin
            timeout_r    <= auto_timeout;
            tcnt_r       <= {TIMEOUT_W{1'b0}};
            auto_fired_r <= 1'b0;
        end else if (state_r == ST_WAIT_TRIG) begin
            tcnt_r <= tcnt_r + TIMEOUT_W'(1'b1);
            if (auto_hit_s && !trig_valid) begin
                auto_fired_r <= 1'b1;
            end
        end
    end
`else
    assign trig_fire_s = (state_r == ST_WAIT_TRIG) && trig_valid;
    assign trig_base_s = trig_addr;
`endif

    assign issue_s   = (state_r == ST_READ) && (issued_r != len_r)
                       && (osc_committed(occ_s, inflight_r) < 2'd2);
    assign hs_last_s = fifo_valid_s && m_ready && fifo_data_s[DATA_WIDTH];

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE:      if (arm)         state_nx_s = ST_WAIT_TRIG; else state_nx_s = ST_IDLE;
            ST_WAIT_TRIG: if (trig_fire_s) state_nx_s = ST_READ;      else state_nx_s = ST_WAIT_TRIG;
            ST_READ:      if (hs_last_s)   state_nx_s = ST_DONE;      else state_nx_s = ST_READ;
            ST_DONE:      if (arm)         state_nx_s = ST_WAIT_TRIG; else state_nx_s = ST_DONE;
            default:                       state_nx_s = ST_IDLE;
        endcase
    end

    // Frame parameters, read address/count and the single-cycle read pipeline.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            len_r           <= LEN_W'(1'b1);
            pre_r           <= {LEN_W{1'b0}};
            frame_start_r   <= {ADDR_W{1'b0}};
            rd_addr_r       <= {ADDR_W{1'b0}};
            issued_r        <= {LEN_W{1'b0}};
            inflight_r      <= 1'b0;
            inflight_last_r <= 1'b0;
        end else begin
            if (arm_ok_s) begin
                len_r <= len_eff_s;
                pre_r <= pre_clamp_s;
            end
            if (trig_fire_s) begin
                frame_start_r <= trig_base_s - ADDR_W'(pre_r);
                rd_addr_r     <= trig_base_s - ADDR_W'(pre_r);
                issued_r      <= {LEN_W{1'b0}};
            end else if (issue_s) begin
                rd_addr_r <= rd_addr_r + ADDR_W'(1'b1);
                issued_r  <= issued_r + LEN_W'(1'b1);
            end
            inflight_r      <= issue_s;
            inflight_last_r <= issue_s && (issued_r == len_r - LEN_W'(1'b1));
        end
    end

    osc_out_fifo2 #(
        .W (DATA_WIDTH + 1)
    ) u_out_fifo (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (inflight_r),
        .in_data   ({inflight_last_r, rd_data}),
        .out_valid (fifo_valid_s),
        .out_data  (fifo_data_s),
        .out_ready (m_ready),
        .count     (occ_s)
    );

    assign rd_en       = issue_s;
    assign rd_addr     = rd_addr_r;
    assign m_valid     = fifo_valid_s;
    assign m_data      = fifo_data_s[DATA_WIDTH-1:0];
    assign m_last      = fifo_data_s[DATA_WIDTH];
    assign done        = hs_last_s;
    assign busy        = (state_r == ST_WAIT_TRIG) || (state_r == ST_READ);
    assign frame_start = frame_start_r;

endmodule
